// File: rtl/shift_sequencer_if.sv
// Handshake and shifter-datapath bundle for shift_sequencer.
// `define SHIFT_SEQ_ABORT_EN adds the abort request line.
interface shift_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
);
  logic             start;
  logic [1:0]       op;
  logic [CNT_W-1:0] amount;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] sh_in;
  logic [1:0]       sh_code;
  logic [WIDTH-1:0] sh_out;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
`ifdef SHIFT_SEQ_ABORT_EN
  logic             abort;
`endif

  // master is the environment: instruction controller plus the combinational shifter
  modport master (
`ifdef SHIFT_SEQ_ABORT_EN
    output abort,
`endif
    output start, op, amount, din, sh_out,
    input  sh_in, sh_code, busy, done, result
  );

  modport slave (
`ifdef SHIFT_SEQ_ABORT_EN
    input  abort,
`endif
    input  start, op, amount, din, sh_out,
    output sh_in, sh_code, busy, done, result
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle N-position shift controller driving an external 1-bit shifter, one step per cycle.
// `define SHIFT_SEQ_ABORT_EN adds an abort input that cancels a shift in progress.
//
// state | meaning
// IDLE  | waiting for start; working register and result hold
// SHIFT | one shifter step per cycle; cnt holds the steps still to do
// DONE  | one-cycle done pulse with result valid, then IDLE
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input logic             clk,
  input logic             reset,
  shift_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_req;

`ifdef SHIFT_SEQ_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      work_q  <= '0;
      op_q    <= 2'b00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          work_d = bus.din;
          op_d   = bus.op;
          cnt_d  = bus.amount;
          // pass and zero-amount requests skip the shifter, so SHIFT never sees cnt==0
          if (bus.amount == '0 || bus.op == 2'b00) state_d = DONE;
          else                                    state_d = SHIFT;
        end
      end
      SHIFT: begin
        // the step on an aborting edge still lands, leaving the partial result visible
        work_d = bus.sh_out;
        cnt_d  = cnt_q - CNT_W'(1);
        if (abort_req)                 state_d = IDLE;
        else if (cnt_q == CNT_W'(1))   state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.sh_in   = work_q;
  assign bus.sh_code = (state_q == SHIFT) ? op_q : 2'b00;
  assign bus.busy    = (state_q == SHIFT) || (state_q == DONE);
  assign bus.done    = (state_q == DONE);
  assign bus.result  = work_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized self-checking bench for shift_sequencer against a whole-shift reference model.
// Abort scenarios are exercised when SHIFT_SEQ_ABORT_EN is defined.
module tb_shift_sequencer;
  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shift_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // external single-position shifter
  always_comb begin
    case (bus.sh_code)
      2'b01:   bus.sh_out = bus.sh_in << 1;
      2'b10:   bus.sh_out = bus.sh_in >> 1;
      2'b11:   bus.sh_out = {bus.sh_in[WIDTH-1], bus.sh_in[WIDTH-1:1]};
      default: bus.sh_out = bus.sh_in;
    endcase
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] d,
                                                 input logic [1:0] o, input int n);
    logic signed [WIDTH-1:0] s;
    s = d;
    case (o)
      2'b01:   return d << n;
      2'b10:   return d >> n;
      2'b11:   return s >>> n;
      default: return d;
    endcase
  endfunction

  // Start one operation and follow it to its done pulse. noise pulses start with junk
  // operands during SHIFT and DONE; immediate starts on the current negedge.
  task automatic run_op(input logic [WIDTH-1:0] d, input logic [1:0] o,
                        input logic [CNT_W-1:0] a, input bit noise, input bit immediate,
                        input string tag);
    logic [WIDTH-1:0] exp;
    int exp_lat, lat, sh_cyc;
    bit got;
    exp     = ref_shift(d, o, (o == 2'b00) ? 0 : int'(a));
    exp_lat = (a == '0 || o == 2'b00) ? 1 : int'(a) + 1;
    if (!immediate) @(negedge clk);
    bus.start = 1'b1; bus.din = d; bus.op = o; bus.amount = a;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1; sh_cyc = 0; got = 1'b0;
    while (lat <= 40) begin
      if (bus.done) begin got = 1'b1; break; end
      chk({tag, " busy_shift"}, bus.busy, 1);
      chk({tag, " sh_code"}, bus.sh_code, o);
      if (bus.sh_code != 2'b00) sh_cyc++;
      bus.din = WIDTH'($urandom); bus.op = 2'($urandom); bus.amount = CNT_W'($urandom);
      bus.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({tag, " done_seen"}, got, 1);
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " result"}, bus.result, exp);
    chk({tag, " steps"}, sh_cyc, exp_lat - 1);
    chk({tag, " busy_done"}, bus.busy, 1);
    chk({tag, " code_done"}, bus.sh_code, 0);
    bus.start = noise; bus.din = WIDTH'($urandom); bus.op = 2'b01; bus.amount = 4'd3;
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, " idle_busy"}, bus.busy, 0);
    chk({tag, " idle_done"}, bus.done, 0);
    chk({tag, " hold"}, bus.result, exp);
  endtask

  initial begin
    reset = 1'b0;
    bus.start = 1'b0; bus.din = '0; bus.op = 2'b00; bus.amount = '0;
`ifdef SHIFT_SEQ_ABORT_EN
    bus.abort = 1'b0;
`endif
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst busy", bus.busy, 0);
    chk("rst done", bus.done, 0);
    chk("rst result", bus.result, 0);
    chk("rst code", bus.sh_code, 0);
    reset = 1'b0;

    run_op(16'h0001, 2'b01, 4'd4, 1'b0, 1'b0, "lsl4");
    chk("lsl4 const", bus.result, 16'h0010);
    run_op(16'h8000, 2'b11, 4'd15, 1'b0, 1'b0, "asr15");
    chk("asr15 const", bus.result, 16'hFFFF);
    run_op(16'h8000, 2'b10, 4'd15, 1'b0, 1'b0, "lsr15");
    chk("lsr15 const", bus.result, 16'h0001);
    run_op(16'hABCD, 2'b10, 4'd0, 1'b0, 1'b0, "zero");
    chk("zero const", bus.result, 16'hABCD);
    run_op(16'hABCD, 2'b00, 4'd7, 1'b0, 1'b0, "pass");
    run_op(16'h1234, 2'b01, 4'd5, 1'b1, 1'b0, "noise");
    chk("noise const", bus.result, 16'h4680);
    run_op(16'hF00F, 2'b11, 4'd2, 1'b0, 1'b1, "b2b");
    chk("b2b const", bus.result, 16'hFC03);

    // reset mid-SHIFT clears outputs without a clock edge
    @(negedge clk);
    bus.start = 1'b1; bus.din = 16'h00F0; bus.op = 2'b01; bus.amount = 4'd8;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst busy", bus.busy, 0);
    chk("midrst done", bus.done, 0);
    chk("midrst result", bus.result, 0);
    chk("midrst code", bus.sh_code, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("postrst done", bus.done, 0);
      chk("postrst busy", bus.busy, 0);
    end

    for (int i = 0; i < 30; i++) begin
      logic [CNT_W-1:0] a;
      a = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 4'd15 : 4'd0)
                                      : CNT_W'($urandom);
      run_op(WIDTH'($urandom), 2'($urandom), a, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), "rand");
    end

`ifdef SHIFT_SEQ_ABORT_EN
    begin
      logic [WIDTH-1:0] d;
      logic [1:0] o;
      @(negedge clk);
      bus.start = 1'b1; bus.din = 16'h00FF; bus.op = 2'b10; bus.amount = 4'd8;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      chk("abort3 done", bus.done, 0);
      chk("abort3 busy", bus.busy, 0);
      chk("abort3 result", bus.result, 16'h001F);
      @(negedge clk);
      chk("abort3 nodone", bus.done, 0);

      d = WIDTH'($urandom); o = 2'($urandom_range(1, 3));
      @(negedge clk);
      bus.start = 1'b1; bus.din = d; bus.op = o; bus.amount = 4'd3;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      chk("abortlast done", bus.done, 0);
      chk("abortlast busy", bus.busy, 0);
      chk("abortlast result", bus.result, ref_shift(d, o, 3));
      @(negedge clk);
      chk("abortlast nodone", bus.done, 0);

      @(negedge clk);
      bus.abort = 1'b1;
      bus.start = 1'b1; bus.din = 16'h0003; bus.op = 2'b01; bus.amount = 4'd2;
      @(negedge clk);
      bus.start = 1'b0; bus.abort = 1'b0;
      chk("abortidle busy", bus.busy, 1);
      @(negedge clk);
      bus.abort = 1'b0;
      @(negedge clk);
      bus.abort = 1'b1;
      chk("abortdone done", bus.done, 1);
      @(negedge clk);
      bus.abort = 1'b0;
      chk("abortdone result", bus.result, 16'h000C);
      chk("abortdone busy", bus.busy, 0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
